// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state type and one-hot helpers for the sequenced N-to-2^N decoder
package decoder_pkg;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_t;

    function automatic int out_width(input int n);
        return 1 << n;
    endfunction

    // Wide enough for the largest legal N (8); callers truncate to their own width.
    function automatic logic [255:0] onehot(input logic [7:0] idx, input int n);
        return (256'(1) << idx) & ~({256{1'b1}} << out_width(n));
    endfunction

endpackage

// File: rtl/decoder_nxm_seq_onehot_dec.sv
// onehot_dec: combinational N-to-2^N one-hot decoder
//   sel  in  N     index to decode
//   dec  out 2^N   one-hot result, bit sel set
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          sel,
    output logic [out_width(N)-1:0] dec
);
    localparam int OUT_W = out_width(N);

    assign dec = OUT_W'(onehot(8'(sel), N));

endmodule

// File: rtl/decoder_nxm_seq.sv
// decoder_nxm_seq: registered one-hot decoder with valid/ready load and auto-scan
//   clk, rst (async, high)    clock and reset
//   clear                     synchronous abort to IDLE
//   in_valid/in_ready, in     load handshake and index; scan picks direct or scan mode
//   out                       registered one-hot (inverted when ACTIVE_LOW)
//   idx                       index currently driven, 0 when idle
//   busy                      high while scanning
//   done                      one-cycle pulse at end of a scan pass
module decoder_nxm_seq
    import decoder_pkg::*;
#(
    parameter int N          = 4,
    parameter int DWELL      = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in,
    input  logic                    scan,
    output logic [out_width(N)-1:0] out,
    output logic [N-1:0]            idx,
    output logic                    busy,
    output logic                    done
);
    localparam int OUT_W = out_width(N);
    localparam int CW    = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [N:0]    PASS_LAST  = (N+1)'(OUT_W - 1);
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

    dec_state_t      state, state_n;
    logic [N-1:0]    idx_n;
    logic [CW-1:0]   dwell, dwell_n;
    logic [N:0]      pass, pass_n;
    logic            done_n;
    logic [OUT_W-1:0] dec;

    wire load       = in_valid && in_ready;
    wire dwell_last = dwell == DWELL_LAST;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        dwell_n = dwell;
        pass_n  = pass;
        done_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            idx_n   = '0;
            dwell_n = '0;
            pass_n  = '0;
        end else if (state == SCAN) begin
            dwell_n = dwell_last ? '0 : dwell + 1'b1;
            if (dwell_last && pass == PASS_LAST) begin
                state_n = IDLE;
                idx_n   = '0;
                pass_n  = '0;
                done_n  = 1'b1;
            end else if (dwell_last) begin
                idx_n  = idx + 1'b1;
                pass_n = pass + 1'b1;
            end
        end else if (load) begin
            state_n = scan ? SCAN : DIRECT;
            idx_n   = in;
            dwell_n = '0;
            pass_n  = '0;
        end
    end

    // Decode the next index so out/idx update on the same edge from flops only.
    onehot_dec #(.N(N)) u_dec (
        .sel (idx_n),
        .dec (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            dwell    <= '0;
            pass     <= '0;
            out      <= INACTIVE;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            dwell    <= dwell_n;
            pass     <= pass_n;
            out      <= (state_n == IDLE ? '0 : dec) ^ INACTIVE;
            busy     <= state_n == SCAN;
            done     <= done_n;
            in_ready <= state_n != SCAN;
        end
    end

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// tb_decoder_nxm_seq: table-driven and scoreboarded checks of decoder_nxm_seq
module tb_decoder_nxm_seq;

    typedef struct {
        int          unit;
        logic [15:0] out;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
        logic        rdy;
    } sb_t;

    typedef struct {
        logic        v;
        logic [3:0]  din;
        logic        s;
        logic [15:0] exp_out;
        logic [3:0]  exp_idx;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, scan = 1'b0;
    logic [3:0] din = '0;

    logic [15:0] out0, outa;
    logic [7:0]  out3;
    logic [3:0]  idx0, idxa;
    logic [2:0]  idx3;
    logic rdy0, busy0, done0, rdya, busya, donea, rdy3, busy3, done3;

    int checks = 0;
    int errors = 0;
    sb_t sb_q[$];
    vec_t vecs[38];

    always #5 clk = ~clk;

    decoder_nxm_seq #(.N(4), .DWELL(2), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
        .in(din), .scan(scan), .out(out0), .idx(idx0), .busy(busy0), .done(done0));

    decoder_nxm_seq #(.N(4), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdya),
        .in(din), .scan(scan), .out(outa), .idx(idxa), .busy(busya), .done(donea));

    decoder_nxm_seq #(.N(3), .DWELL(3), .ACTIVE_LOW(1'b0)) dut3 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy3),
        .in(din[2:0]), .scan(scan), .out(out3), .idx(idx3), .busy(busy3), .done(done3));

    function automatic sb_t mk(int u, logic [15:0] o, logic [3:0] i, logic b, logic d, logic r);
        sb_t e;
        e.unit = u; e.out = o; e.idx = i; e.busy = b; e.done = d; e.rdy = r;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare(input sb_t e);
        logic [15:0] o;
        logic [3:0] i;
        logic b, d, r;
        o = e.unit == 0 ? out0 : e.unit == 1 ? outa : {8'h00, out3};
        i = e.unit == 0 ? idx0 : e.unit == 1 ? idxa : {1'b0, idx3};
        b = e.unit == 0 ? busy0 : e.unit == 1 ? busya : busy3;
        d = e.unit == 0 ? done0 : e.unit == 1 ? donea : done3;
        r = e.unit == 0 ? rdy0 : e.unit == 1 ? rdya : rdy3;
        chk($sformatf("u%0d out", e.unit), 32'(o), 32'(e.out));
        chk($sformatf("u%0d idx", e.unit), 32'(i), 32'(e.idx));
        chk($sformatf("u%0d busy", e.unit), 32'(b), 32'(e.busy));
        chk($sformatf("u%0d done", e.unit), 32'(d), 32'(e.done));
        chk($sformatf("u%0d in_ready", e.unit), 32'(r), 32'(e.rdy));
    endtask

    task automatic expect_now(input sb_t e);
        sb_q.push_back(e);
        compare(sb_q.pop_front());
    endtask

    task automatic step(input logic v, input logic [3:0] i, input logic s, input logic c, input sb_t e);
        @(negedge clk);
        in_valid = v; din = i; scan = s; clear = c;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 4'd5, 1'b0, 16'h0020, 4'd5};
        for (int k = 1; k <= 20; k++) vecs[k] = '{1'b0, 4'd0, 1'b0, 16'h0020, 4'd5};
        vecs[21] = '{1'b1, 4'd15, 1'b0, 16'h8000, 4'd15};
        for (int k = 0; k < 16; k++) vecs[22+k] = '{1'b1, 4'(k), 1'b0, 16'(1) << k, 4'(k)};

        repeat (2) @(posedge clk);
        #2;
        expect_now(mk(0, 16'h0000, 0, 0, 0, 1));
        expect_now(mk(1, 16'hFFFF, 0, 0, 0, 1));
        expect_now(mk(2, 16'h0000, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 38; k++) begin
            step(vecs[k].v, vecs[k].din, vecs[k].s, 1'b0, mk(0, vecs[k].exp_out, vecs[k].exp_idx, 0, 0, 1));
            expect_now(mk(1, ~vecs[k].exp_out, vecs[k].exp_idx, 0, 0, 1));
            chk("onehot count", 32'($countones(out0)), 32'd1);
        end

        step(1'b1, 4'd14, 1'b1, 1'b0, mk(0, 16'h4000, 4'd14, 1, 0, 0));
        for (int c = 1; c < 32; c++) begin
            logic [3:0] p;
            p = 4'((14 + c / 2) % 16);
            step(c % 5 == 0, 4'd3, 1'b0, 1'b0, mk(0, 16'(1) << p, p, 1, 0, 0));
        end
        step(1'b1, 4'd2, 1'b0, 1'b0, mk(0, 16'h0000, 4'd0, 0, 1, 1));
        step(1'b1, 4'd2, 1'b0, 1'b0, mk(0, 16'h0004, 4'd2, 0, 0, 1));

        step(1'b1, 4'd0, 1'b1, 1'b0, mk(0, 16'h0001, 4'd0, 1, 0, 0));
        for (int c = 1; c < 7; c++)
            step(1'b0, 4'd0, 1'b0, 1'b0, mk(0, 16'(1) << (c / 2), 4'(c / 2), 1, 0, 0));
        step(1'b1, 4'd9, 1'b0, 1'b1, mk(0, 16'h0000, 4'd0, 0, 0, 1));
        step(1'b0, 4'd0, 1'b0, 1'b0, mk(0, 16'h0000, 4'd0, 0, 0, 1));
        step(1'b0, 4'd0, 1'b0, 1'b0, mk(0, 16'h0000, 4'd0, 0, 0, 1));

        step(1'b1, 4'd0, 1'b1, 1'b0, mk(2, 16'h0001, 4'd0, 1, 0, 0));
        for (int c = 1; c < 5; c++)
            step(1'b0, 4'd0, 1'b0, 1'b0, mk(2, 16'(1) << (c / 3), 4'(c / 3), 1, 0, 0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_now(mk(2, 16'h0000, 0, 0, 0, 1));
        expect_now(mk(0, 16'h0000, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 4'd0, 1'b1, 1'b0, mk(2, 16'h0001, 4'd0, 1, 0, 0));
        for (int c = 1; c < 24; c++)
            step(1'b0, 4'd0, 1'b0, 1'b0, mk(2, 16'(1) << (c / 3), 4'(c / 3), 1, 0, 0));
        step(1'b0, 4'd0, 1'b0, 1'b0, mk(2, 16'h0000, 4'd0, 0, 1, 1));
        step(1'b0, 4'd0, 1'b0, 1'b0, mk(2, 16'h0000, 4'd0, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
